// File: rtl/alu_exec_unit_if.sv
// Issue-side and CDB-side signal bundle of the integer execution unit.
// The slave modport is the execution unit. The master modport is the queue/arbiter side.
interface alu_exec_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic              issue_valid;
  logic [DATA_W-1:0] op1_data;
  logic [DATA_W-1:0] op2_data;
  logic [2:0]        funct3;
  logic [2:0]        alu_ext;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_tag_valid;
  logic              ex_done;
  logic              cdb_req;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_grant;
  logic              busy;

  modport master (
    output issue_valid, op1_data, op2_data, funct3, alu_ext, rd_tag, rd_tag_valid,
    output cdb_grant,
    input  ex_done, cdb_req, cdb_tag, cdb_data, busy
  );

  modport slave (
    input  issue_valid, op1_data, op2_data, funct3, alu_ext, rd_tag, rd_tag_valid,
    input  cdb_grant,
    output ex_done, cdb_req, cdb_tag, cdb_data, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I ALU stage feeding an in-order result buffer that publishes on the CDB via req/grant.
// Result visible on the CDB one cycle after issue; a full, ungranted buffer holds off ex_done.
module alu_exec_unit #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_result;
  logic [4:0]        w_shamt;
  logic              w_alt;
  logic              w_req;
  logic              w_pop;
  logic              w_accept;
  logic              w_done;
  logic              w_push;
  ent_t              w_head;

  always_comb begin
    w_shamt  = bus.op2_data[4:0];
    w_alt    = (bus.alu_ext == 3'b001);
    w_result = '0;
    case (bus.funct3)
      3'b000:  w_result = w_alt ? (bus.op1_data - bus.op2_data)
                                : (bus.op1_data + bus.op2_data);
      3'b001:  w_result = bus.op1_data << w_shamt;
      3'b010:  w_result = {{(DATA_W-1){1'b0}},
                           ($signed(bus.op1_data) < $signed(bus.op2_data))};
      3'b011:  w_result = {{(DATA_W-1){1'b0}}, (bus.op1_data < bus.op2_data)};
      3'b100:  w_result = bus.op1_data ^ bus.op2_data;
      3'b101:  w_result = w_alt ? $unsigned($signed(bus.op1_data) >>> w_shamt)
                                : (bus.op1_data >> w_shamt);
      3'b110:  w_result = bus.op1_data | bus.op2_data;
      default: w_result = bus.op1_data & bus.op2_data;
    endcase
    // LUI-style pass-through wins over whatever funct3 selected
    if (bus.alu_ext == 3'b010) begin
      w_result = bus.op2_data;
    end
  end

  // A granted head frees its slot in the same cycle, so a full buffer can still accept.
  assign w_req    = (r_count != '0);
  assign w_pop    = w_req & bus.cdb_grant;
  assign w_accept = (r_count < CNT_W'(DEPTH)) | w_pop;
  assign w_done   = rst & bus.issue_valid & w_accept;
  assign w_push   = w_done & bus.rd_tag_valid;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{tag: bus.rd_tag, data: w_result};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ex_done  = w_done;
  assign bus.cdb_req  = w_req;
  assign bus.busy     = w_req;
  assign bus.cdb_tag  = w_req ? w_head.tag  : '0;
  assign bus.cdb_data = w_req ? w_head.data : '0;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    r_count <= CNT_W'(DEPTH));

  a_head_stable: assert property (@(posedge clk) disable iff (!rst)
    (w_req && !bus.cdb_grant) |=> ($stable(bus.cdb_tag) && $stable(bus.cdb_data)));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: ALU ops, backpressure, full push/pop and reset behaviour.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(32), .TAG_W(6)) bus ();

  alu_exec_unit #(.DEPTH(2), .DATA_W(32), .TAG_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] f3, input logic [2:0] ext,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic tv, input logic gnt);
    @(posedge clk);
    #1;
    bus.issue_valid  = iv;
    bus.funct3       = f3;
    bus.alu_ext      = ext;
    bus.op1_data     = a;
    bus.op2_data     = b;
    bus.rd_tag       = tag;
    bus.rd_tag_valid = tv;
    bus.cdb_grant    = gnt;
  endtask

  // ALU vectors: funct3, alu_ext, op1, op2, expected result
  logic [2:0]  v_f3  [13] = '{3'd0, 3'd0, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1};
  logic [2:0]  v_ext [13] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
  logic [31:0] v_a   [13] = '{32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd99,
                              32'd1, 32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0,
                              32'd1, 32'd3};
  logic [31:0] v_b   [13] = '{32'd5, 32'd7, 32'd4, 32'd1, 32'd1, 32'h1234_5000,
                              32'd31, 32'd4, 32'h0000_FF00, 32'h0000_0F00, 32'h0000_FF00,
                              32'd2, 32'h21};
  logic [31:0] v_exp [13] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0, 32'h1234_5000,
                              32'h8000_0000, 32'h0800_0000, 32'h0000_0FF0, 32'h0000_FFF0,
                              32'h0000_F000, 32'd3, 32'd6};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.issue_valid = 1'b0; bus.funct3 = '0; bus.alu_ext = '0; bus.op1_data = '0;
    bus.op2_data = '0; bus.rd_tag = '0; bus.rd_tag_valid = 1'b0; bus.cdb_grant = 1'b0;

    // Reset held with an issue pending
    drive(1'b1, 3'd0, 3'd0, 32'd1, 32'd1, 6'd9, 1'b1, 1'b1);
    drive(1'b1, 3'd0, 3'd0, 32'd1, 32'd1, 6'd9, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_ex_done", 32'(bus.ex_done), 32'd0);
    check("rst_cdb_req", 32'(bus.cdb_req), 32'd0);
    check("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
    check("rst_cdb_data", bus.cdb_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.issue_valid = 1'b0;
    rst = 1'b1;

    // ALU ops, grant tied high, one issue per cycle
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, v_f3[i], v_ext[i], v_a[i], v_b[i], 6'(3 + i), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("alu_ex_done_%0d", i), 32'(bus.ex_done), 32'd1);
      if (i == 0) begin
        check("alu_first_latency", 32'(bus.cdb_req), 32'd0);
      end else begin
        check($sformatf("alu_req_%0d", i - 1), 32'(bus.cdb_req), 32'd1);
        check($sformatf("alu_tag_%0d", i - 1), 32'(bus.cdb_tag), 32'(3 + i - 1));
        check($sformatf("alu_data_%0d", i - 1), bus.cdb_data, v_exp[i - 1]);
      end
    end
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("alu_tag_12", 32'(bus.cdb_tag), 32'd15);
    check("alu_data_12", bus.cdb_data, 32'd6);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("alu_drained_req", 32'(bus.cdb_req), 32'd0);
    check("alu_drained_busy", 32'(bus.busy), 32'd0);

    // Backpressure: grant low, tags 1,2,3 (result = 100 + tag)
    drive(1'b1, 3'd0, 3'd0, 32'd101, 32'd0, 6'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_done_1", 32'(bus.ex_done), 32'd1);
    drive(1'b1, 3'd0, 3'd0, 32'd102, 32'd0, 6'd2, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_done_2", 32'(bus.ex_done), 32'd1);
    check("bp_head_a", 32'(bus.cdb_tag), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd0, 3'd0, 32'd103, 32'd0, 6'd3, 1'b1, 1'b0);
      @(negedge clk);
      check("bp_done_3_full", 32'(bus.ex_done), 32'd0);
      check("bp_head_tag", 32'(bus.cdb_tag), 32'd1);
      check("bp_head_data", bus.cdb_data, 32'd101);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    drive(1'b1, 3'd0, 3'd0, 32'd103, 32'd0, 6'd3, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_done_3_pop", 32'(bus.ex_done), 32'd1);
    check("bp_order_1", 32'(bus.cdb_tag), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_order_2", 32'(bus.cdb_tag), 32'd2);
    check("bp_data_2", bus.cdb_data, 32'd102);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_order_3", 32'(bus.cdb_tag), 32'd3);
    check("bp_data_3", bus.cdb_data, 32'd103);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_empty_req", 32'(bus.cdb_req), 32'd0);
    check("bp_empty_tag", 32'(bus.cdb_tag), 32'd0);

    // Fill, then sustained push+pop while full
    drive(1'b1, 3'd0, 3'd0, 32'd20, 32'd0, 6'd20, 1'b1, 1'b0);
    drive(1'b1, 3'd0, 3'd0, 32'd21, 32'd0, 6'd21, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd0, 3'd0, 32'(22 + k), 32'd0, 6'(22 + k), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("full_done_%0d", k), 32'(bus.ex_done), 32'd1);
      check($sformatf("full_count_%0d", k), 32'(dut.r_count), 32'd2);
      check($sformatf("full_head_%0d", k), 32'(bus.cdb_tag), 32'(20 + k));
      check($sformatf("full_data_%0d", k), bus.cdb_data, 32'(20 + k));
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("full_drain_%0d", k), 32'(bus.cdb_tag), 32'(26 + k));
    end
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("full_empty", 32'(bus.busy), 32'd0);

    // No-destination instruction retires without touching the buffer
    drive(1'b1, 3'd0, 3'd0, 32'd4, 32'd4, 6'd40, 1'b0, 1'b1);
    @(negedge clk);
    check("nodst_done", 32'(bus.ex_done), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("nodst_req", 32'(bus.cdb_req), 32'd0);
    check("nodst_busy", 32'(bus.busy), 32'd0);

    // Reset mid-operation with two results buffered
    drive(1'b1, 3'd0, 3'd0, 32'd50, 32'd0, 6'd50, 1'b1, 1'b0);
    drive(1'b1, 3'd0, 3'd0, 32'd51, 32'd0, 6'd51, 1'b1, 1'b0);
    drive(1'b1, 3'd0, 3'd0, 32'd52, 32'd0, 6'd52, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ex_done", 32'(bus.ex_done), 32'd0);
    drive(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst_req_%0d", k), 32'(bus.cdb_req), 32'd0);
      check($sformatf("midrst_tag_%0d", k), 32'(bus.cdb_tag), 32'd0);
      check($sformatf("midrst_busy_%0d", k), 32'(bus.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
